mdu_iter: RTL and testbench

- Multi-cycle, parametrised RV64M/RV32M multiply-divide unit that replaces the single-cycle simulation MDU in the EX stage.
- Operands are accepted through a valid/ready handshake and computed with iterative shift-add multiplication and restoring division.
- The result is returned through a second valid/ready handshake, so the pipeline can stall on `in_ready` and `out_valid`.
- Supports all M and M-W operations, with the RISC-V special cases resolved early.

---
 rtl/mdu_iter_pkg.sv | 52 +++++
 rtl/mdu_iter_div_restore.sv | 48 ++++
 rtl/mdu_iter.sv | 183 ++++++++++++++++++
 tb/tb_mdu_iter.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/mdu_iter_pkg.sv
// Shared definitions for the iterative multiply-divide unit.
// Opcode encodings are {inst_32, funct3}; the helpers classify an opcode
// by result selection and operand signedness.
package mdu_iter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } mdu_state_e;

  localparam logic [3:0] OpMul    = 4'b0000;
  localparam logic [3:0] OpMulh   = 4'b0001;
  localparam logic [3:0] OpMulhsu = 4'b0010;
  localparam logic [3:0] OpMulhu  = 4'b0011;
  localparam logic [3:0] OpDiv    = 4'b0100;
  localparam logic [3:0] OpDivu   = 4'b0101;
  localparam logic [3:0] OpRem    = 4'b0110;
  localparam logic [3:0] OpRemu   = 4'b0111;
  localparam logic [3:0] OpMulw   = 4'b1000;
  localparam logic [3:0] OpDivw   = 4'b1100;
  localparam logic [3:0] OpDivuw  = 4'b1101;
  localparam logic [3:0] OpRemw   = 4'b1110;
  localparam logic [3:0] OpRemuw  = 4'b1111;

  function automatic logic is_div(input logic [3:0] op);
    return op[2];
  endfunction

  function automatic logic is_rem(input logic [3:0] op);
    return op[2] & op[1];
  endfunction

  function automatic logic is_high(input logic [3:0] op);
    return !op[2] && (op[1:0] != 2'b00);
  endfunction

  // Low-half multiplies are sign-agnostic, so MUL/MULW use unsigned magnitudes.
  function automatic logic rs1_signed(input logic [3:0] op);
    return op[2] ? !op[0] : ((op[1:0] == 2'b01) || (op[1:0] == 2'b10));
  endfunction

  function automatic logic rs2_signed(input logic [3:0] op);
    return op[2] ? !op[0] : (op[1:0] == 2'b01);
  endfunction

  // W forms only exist for MULW and the four divides.
  function automatic logic is_valid_op(input logic [3:0] op);
    return !op[3] || op[2] || (op[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/mdu_iter_div_restore.sv
// Restoring divider datapath: one quotient bit per step on unsigned magnitudes.
// Ports: clk/rst, load (capture operands), step (retire one bit), w32 (32-bit
// operation: dividend is pre-shifted so its top bit is consumed first),
// dividend/divisor magnitudes, quotient/remainder magnitudes.
module mdu_iter_div_restore #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            w32,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic [XLEN-1:0] rem_q, quo_q, dsr_q;
  logic [XLEN:0]   rem_sh, diff;
  logic            fits;

  always_comb begin
    rem_sh = {rem_q, quo_q[XLEN-1]};
    diff   = rem_sh - {1'b0, dsr_q};
    fits   = !diff[XLEN];
  end

  // quo_q doubles as the dividend shift register; quotient bits enter at the bottom.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= w32 ? (dividend << (XLEN - 32)) : dividend;
      dsr_q <= divisor;
    end else if (step) begin
      rem_q <= fits ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
      quo_q <= {quo_q[XLEN-2:0], fits};
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV64M/RV32M multiply-divide unit with valid/ready on both sides.
// Ports: clk, rst (sync, active-high), flush (abandon in-flight op),
// in_valid/in_ready + funct3/inst_32/x_rs1/x_rs2 (request),
// out_valid/out_ready + mdu_result (response, W forms sign-extended).
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int unsigned XLEN          = 64,
  parameter int unsigned MUL_BITS      = 1,
  parameter bit          EARLY_SPECIAL = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic            inst_32,
  input  logic [XLEN-1:0] x_rs1,
  input  logic [XLEN-1:0] x_rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] mdu_result
);

  localparam int unsigned CntW = $clog2(XLEN + 1);

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = '0;
    r[31:0] = v;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] fit_w(input logic [XLEN-1:0] v, input logic w);
    return w ? sext32(v[31:0]) : v;
  endfunction

  mdu_state_e        state_q;
  logic [3:0]        op_q;
  logic              neg_q, short_q;
  logic [CntW-1:0]   cnt_q;
  logic [XLEN-1:0]   mcand_q;
  logic [2*XLEN-1:0] prod_q;

  logic [3:0]           op_in;
  logic [XLEN-1:0]      a_ext, b_ext, mag1, mag2, most_neg, short_res;
  logic                 s1, s2, div0, ovf, short_in, neg_in, accept;
  logic [CntW-1:0]      iters;
  logic [XLEN+MUL_BITS-1:0] mul_acc;
  logic [2*XLEN-1:0]    prod_d, prod_s;
  logic [XLEN-1:0]      div_quo, div_rem, div_v, calc_res;
  logic                 div_load, div_step;

  // Request decode: operands become magnitudes plus a single negate flag.
  always_comb begin
    op_in = {inst_32, funct3};
    a_ext = x_rs1;
    b_ext = x_rs2;
    if (inst_32) begin
      a_ext = rs1_signed(op_in) ? sext32(x_rs1[31:0]) : zext32(x_rs1[31:0]);
      b_ext = rs2_signed(op_in) ? sext32(x_rs2[31:0]) : zext32(x_rs2[31:0]);
    end
    s1       = rs1_signed(op_in) && a_ext[XLEN-1];
    s2       = rs2_signed(op_in) && b_ext[XLEN-1];
    mag1     = s1 ? -a_ext : a_ext;
    mag2     = s2 ? -b_ext : b_ext;
    most_neg = inst_32 ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
    div0     = (b_ext == '0);
    ovf      = rs1_signed(op_in) && (a_ext == most_neg) && (b_ext == '1);
    short_in = (EARLY_SPECIAL && is_div(op_in) && (div0 || ovf)) || !is_valid_op(op_in);
    short_res = '0;
    if (is_valid_op(op_in)) begin
      if (div0)     short_res = fit_w(is_rem(op_in) ? a_ext : '1, inst_32);
      else if (ovf) short_res = fit_w(is_rem(op_in) ? '0 : a_ext, inst_32);
    end
    // Divide-by-zero quotient is all ones regardless of the dividend sign.
    if (is_div(op_in)) neg_in = is_rem(op_in) ? s1 : ((s1 ^ s2) && !div0);
    else               neg_in = s1 ^ s2;
    if (is_div(op_in)) iters = CntW'(inst_32 ? 32 : XLEN);
    else               iters = CntW'((inst_32 ? 32 : XLEN) / MUL_BITS);
    accept = in_ready && in_valid;
  end

  // Shift-add step: prod_q = {partial product, remaining multiplier bits}.
  always_comb begin
    mul_acc = {{MUL_BITS{1'b0}}, prod_q[2*XLEN-1:XLEN]}
            + {{MUL_BITS{1'b0}}, mcand_q} * {{XLEN{1'b0}}, prod_q[MUL_BITS-1:0]};
    prod_d  = {mul_acc, prod_q[XLEN-1:MUL_BITS]};
  end

  // Sign correction and result selection at the end of CALC.
  always_comb begin
    prod_s = neg_q ? -prod_q : prod_q;
    div_v  = is_rem(op_q) ? div_rem : div_quo;
    div_v  = neg_q ? -div_v : div_v;
    if (is_div(op_q))      calc_res = fit_w(div_v, op_q[3]);
    // After 32 bits retired the W product sits XLEN-32 bits up from the bottom.
    else if (op_q[3])      calc_res = sext32(prod_s[XLEN-1 -: 32]);
    else if (is_high(op_q)) calc_res = prod_s[2*XLEN-1:XLEN];
    else                   calc_res = prod_s[XLEN-1:0];
  end

  assign div_load = accept && !flush;
  assign div_step = (state_q == StCalc) && (cnt_q != '0) && is_div(op_q) && !flush;

  mdu_iter_div_restore #(
    .XLEN(XLEN)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .step     (div_step),
    .w32      (inst_32),
    .dividend (mag1),
    .divisor  (mag2),
    .quotient (div_quo),
    .remainder(div_rem)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      mdu_result <= '0;
      cnt_q      <= '0;
      op_q       <= '0;
      neg_q      <= 1'b0;
      short_q    <= 1'b0;
      mcand_q    <= '0;
      prod_q     <= '0;
    end else if (flush) begin
      state_q   <= StIdle;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            state_q  <= StCalc;
            in_ready <= 1'b0;
            op_q     <= op_in;
            neg_q    <= neg_in;
            short_q  <= short_in;
            mcand_q  <= mag1;
            prod_q   <= {{XLEN{1'b0}}, mag2};
            // Short ops spend one zero-count CALC cycle so they land at E0+1.
            cnt_q    <= short_in ? '0 : iters;
            if (short_in) mdu_result <= short_res;
          end
        end
        StCalc: begin
          if (cnt_q == '0) begin
            if (!short_q) mdu_result <= calc_res;
            out_valid <= 1'b1;
            state_q   <= StDone;
          end else begin
            cnt_q <= cnt_q - 1'b1;
            if (!is_div(op_q)) prod_q <= prod_d;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, inst_32, out_valid, out_ready;
  logic [2:0]  funct3;
  logic [63:0] x_rs1, x_rs2, mdu_result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mdu_iter #(
    .XLEN         (64),
    .MUL_BITS     (1),
    .EARLY_SPECIAL(1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .funct3    (funct3),
    .inst_32   (inst_32),
    .x_rs1     (x_rs1),
    .x_rs2     (x_rs2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mdu_result(mdu_result)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op, measure edges from accept to out_valid, optionally hold the
  // result in DONE for `hold` cycles, then complete the output handshake.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input int exp_lat, input int hold);
    int lat;
    funct3  = f3;
    inst_32 = w;
    x_rs1   = a;
    x_rs2   = b;
    check({tag, "/in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "/latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "/result"}, mdu_result, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, "/hold_result"}, mdu_result, exp);
      check({tag, "/hold_in_ready"}, 64'(in_ready), 64'd0);
      check({tag, "/hold_out_valid"}, 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "/done_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "/done_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic seen;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    funct3 = 3'd0; inst_32 = 1'b0; x_rs1 = '0; x_rs2 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset/in_ready", 64'(in_ready), 64'd1);
    check("reset/out_valid", 64'(out_valid), 64'd0);
    check("reset/result", mdu_result, 64'd0);

    run_op("div_m7_2", 3'd4, 1'b0, -64'sd7, 64'd2, -64'sd3, 65, 0);
    run_op("rem_m7_2", 3'd6, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
    run_op("mulhu_ones", 3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           64'hFFFF_FFFF_FFFF_FFFE, 65, 5);
    run_op("mulh_minneg", 3'd1, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
           64'h4000_0000_0000_0000, 65, 0);
    run_op("mulhsu_m1_2", 3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
           64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
    run_op("mul_5_7", 3'd0, 1'b0, 64'd5, 64'd7, 64'd35, 65, 0);
    run_op("divw_ovf", 3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
           64'hFFFF_FFFF_8000_0000, 1, 0);
    run_op("remw_ovf", 3'd6, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
           64'd0, 1, 0);
    run_op("divu_zero", 3'd5, 1'b0, 64'd12345, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    run_op("remuw_zero", 3'd7, 1'b1, 64'h0000_0001_8000_0000, 64'd0,
           64'hFFFF_FFFF_8000_0000, 1, 0);
    run_op("divuw_ff_1", 3'd5, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1,
           64'hFFFF_FFFF_FFFF_FFFF, 33, 0);

    // Flush a DIV ten cycles into CALC; no result may ever appear.
    funct3 = 3'd4; inst_32 = 1'b0; x_rs1 = -64'sd7; x_rs2 = 64'd2;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush/out_valid", 64'(out_valid), 64'd0);
    check("flush/in_ready", 64'(in_ready), 64'd1);
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("flush/no_out_valid", 64'(seen), 64'd0);
    run_op("mulw_3_m4", 3'd0, 1'b1, 64'd3, 64'hFFFF_FFFF_FFFF_FFFC,
           64'hFFFF_FFFF_FFFF_FFF4, 33, 0);

    // Reset mid-operation drops the op and clears the held result.
    funct3 = 3'd5; inst_32 = 1'b0; x_rs1 = 64'd100; x_rs2 = 64'd3;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst/out_valid", 64'(out_valid), 64'd0);
    check("midrst/in_ready", 64'(in_ready), 64'd1);
    check("midrst/result", mdu_result, 64'd0);
    run_op("divu_100_3", 3'd5, 1'b0, 64'd100, 64'd3, 64'd33, 65, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
